// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo
//   Buffered UART transmitter. Bytes pushed through wr_en/data_in are queued
//   in a small circular FIFO and sent LSB-first on tx. The default frame is
//   8N1: a start bit, eight data bits and one stop bit, each DIV = CLK_HZ/BAUD
//   clocks long. Back-to-back frames are sent with no idle gap between them.
//
//   Optional build macro: UART_TX_PARITY_EN
//     When defined, an even-parity bit (XOR of the 8 data bits) is inserted
//     between the last data bit and the stop bit. Each frame is then
//     11*DIV clocks instead of 10*DIV.
//
// Ports
//   clk         in   system clock; all logic updates on the rising edge
//   rst_n       in   synchronous active-low reset
//   data_in     in   [7:0] byte to enqueue, sampled only on an accepted write
//   wr_en       in   enqueue strobe; the write is accepted when full == 0
//   full        out  FIFO holds FIFO_DEPTH entries (registered)
//   fifo_count  out  bytes waiting, not counting the one on the line (registered)
//   busy        out  a frame is on the line (registered)
//   tx          out  serial line, registered, idles high
// ---------------------------------------------------------------------------
module uart_tx_fifo #(
  parameter int CLK_HZ     = 100000000,
  parameter int BAUD       = 9600,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [7:0]                        data_in,
  input  logic                              wr_en,
  output logic                              full,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
  output logic                              busy,
  output logic                              tx
);

  localparam int DIV = CLK_HZ / BAUD;
  localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW  = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  // Storage. The head entry is read combinationally so the pop and the
  // start bit can happen on the same edge; the FIFO is small enough to sit
  // in distributed RAM.
  logic [7:0] mem [0:FIFO_DEPTH-1];

  state_t          state_q,   state_d;
  logic [TW-1:0]   timer_q,   timer_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q,   shift_d;
  logic            tx_q,      tx_d;
  logic            busy_q,    busy_d;
  logic [AW-1:0]   wr_ptr_q,  wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q,  rd_ptr_d;
  logic [CW-1:0]   count_q,   count_d;
  logic            full_q,    full_d;
`ifdef UART_TX_PARITY_EN
  logic            parity_q,  parity_d;
`endif

  logic            push;
  logic            pop;
  logic            bit_done;
  logic            fifo_nonempty;
  logic [7:0]      head;

  assign push          = wr_en & ~full_q;
  assign bit_done      = (timer_q == TW'(DIV - 1));
  assign fifo_nonempty = (count_q != '0);
  assign head          = mem[rd_ptr_q];

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q + TW'(1);
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    pop       = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif

    case (state_q)
      IDLE: begin
        timer_d = '0;
        tx_d    = 1'b1;
        if (fifo_nonempty) begin
          pop = 1'b1;
        end
      end

      START: begin
        if (bit_done) begin
          state_d   = DATA;
          timer_d   = '0;
          bit_idx_d = 3'd0;
          tx_d      = shift_q[0];
        end
      end

      DATA: begin
        if (bit_done) begin
          timer_d = '0;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
            tx_d    = parity_q;
`else
            state_d = STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            // Next bit is shift_q[1]; present it on the same edge we shift.
            shift_d   = {1'b0, shift_q[7:1]};
            tx_d      = shift_q[1];
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end

`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_done) begin
          state_d = STOP;
          timer_d = '0;
          tx_d    = 1'b1;
        end
      end
`endif

      STOP: begin
        if (bit_done) begin
          timer_d = '0;
          if (fifo_nonempty) begin
            // Chain straight into the next start bit: no idle gap.
            pop = 1'b1;
          end else begin
            state_d = IDLE;
            tx_d    = 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
        timer_d = '0;
        tx_d    = 1'b1;
      end
    endcase

    if (pop) begin
      state_d  = START;
      tx_d     = 1'b0;
      timer_d  = '0;
      shift_d  = head;
      rd_ptr_d = rd_ptr_q + AW'(1);
`ifdef UART_TX_PARITY_EN
      parity_d = ^head;
`endif
    end

    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end

    // A push and pop together leave the count unchanged; push is already
    // suppressed when the FIFO was full before this edge.
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    full_d = (count_d == CW'(FIFO_DEPTH));
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      full_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      full_q    <= full_d;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  // Storage needs no reset: clearing the pointers and count empties it.
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      mem[wr_ptr_q] <= data_in;
    end
  end

  assign tx         = tx_q;
  assign busy       = busy_q;
  assign full       = full_q;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_fifo
//   Directed self-checking bench for uart_tx_fifo with CLK_HZ=16, BAUD=1
//   (DIV=16) and FIFO_DEPTH=4. Inputs change 1 time unit after a rising
//   edge; outputs are sampled at the same point, so each sample shows the
//   state produced by the edge just taken.
// ---------------------------------------------------------------------------
module tb_uart_tx_fifo;

  localparam int DIV = 16;
`ifdef UART_TX_PARITY_EN
  localparam int FL  = 11 * DIV;
`else
  localparam int FL  = 10 * DIV;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] data_in;
  logic       wr_en;
  logic       full;
  logic [2:0] fifo_count;
  logic       busy;
  logic       tx;

  int checks = 0;
  int errors = 0;

  uart_tx_fifo #(
    .CLK_HZ    (16),
    .BAUD      (1),
    .FIFO_DEPTH(4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .data_in   (data_in),
    .wr_en     (wr_en),
    .full      (full),
    .fifo_count(fifo_count),
    .busy      (busy),
    .tx        (tx)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected line level k cycles after the edge that launched a frame of b.
  function automatic logic exp_tx(input logic [7:0] b, input int k);
    if (k < DIV) return 1'b0;
    if (k < 9 * DIV) return b[(k - DIV) / DIV];
`ifdef UART_TX_PARITY_EN
    if (k < 10 * DIV) return ^b;
`endif
    return 1'b1;
  endfunction

  task automatic test_reset();
    int bad;
    rst_n = 1'b0; wr_en = 1'b0; data_in = 8'h00;
    repeat (3) tick();
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx got %b want 1", tx); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", full); end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", fifo_count); end
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL reset_idle_hold got %0d bad cycles want 0", bad); end
    $display("test_reset done");
  endtask

  task automatic test_single_byte();
    data_in = 8'hA5; wr_en = 1'b1;
    tick();                       // edge N
    wr_en = 1'b0; data_in = 8'h00;
    checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL single_count_after_write got %0d want 1", fifo_count); end
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL single_tx_after_write got %b want 1", tx); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_after_write got %b want 0", busy); end
    for (int k = 0; k < FL; k++) begin
      tick();                     // edge N+1+k
      checks++; if (tx !== exp_tx(8'hA5, k)) begin errors++; $display("FAIL single_tx k=%0d got %b want %b", k, tx, exp_tx(8'hA5, k)); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy k=%0d got %b want 1", k, busy); end
      if (k == 0) begin
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL single_count_popped got %0d want 0", fifo_count); end
      end
    end
    tick();                       // edge N+1+FL
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_end got %b want 0", busy); end
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL single_tx_end got %b want 1", tx); end
    $display("test_single_byte done");
  endtask

  task automatic test_back_to_back();
    logic [7:0] b;
    data_in = 8'h01; wr_en = 1'b1;
    tick();                       // edge N: 0x01 queued
    for (int t = 0; t < 5 * FL; t++) begin
      if (t < 5) begin
        data_in = 8'(t + 2);      // 0x02..0x06 on edges N+1..N+5
        wr_en   = 1'b1;
      end else begin
        wr_en   = 1'b0;
      end
      tick();
      b = 8'(t / FL + 1);
      checks++; if (tx !== exp_tx(b, t % FL)) begin errors++; $display("FAIL b2b_tx t=%0d got %b want %b", t, tx, exp_tx(b, t % FL)); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy t=%0d got %b want 1", t, busy); end
      if (t == 3 || t == 4) begin
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL b2b_full t=%0d got %b want 1", t, full); end
        checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL b2b_count t=%0d got %0d want 4", t, fifo_count); end
      end
    end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_end got %b want 0", busy); end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL b2b_count_end got %0d want 0", fifo_count); end
    for (int i = 0; i < 2 * DIV; i++) begin
      tick();
      checks++; if (tx !== 1'b1) begin errors++; $display("FAIL b2b_no_sixth i=%0d got %b want 1", i, tx); end
    end
    $display("test_back_to_back done");
  endtask

  task automatic test_simul_write_pop();
    logic [7:0] seq [4];
    seq[0] = 8'h11; seq[1] = 8'h22; seq[2] = 8'h33; seq[3] = 8'h44;
    data_in = 8'h11; wr_en = 1'b1;
    tick();                       // edge N: 0x11 queued
    for (int t = 0; t < 4 * FL; t++) begin
      if (t == 0)           begin data_in = 8'h22; wr_en = 1'b1; end
      else if (t == 1)      begin data_in = 8'h33; wr_en = 1'b1; end
      else if (t == FL)     begin data_in = 8'h44; wr_en = 1'b1; end  // STOP-completion edge
      else                  begin wr_en = 1'b0; end
      tick();
      checks++; if (tx !== exp_tx(seq[t / FL], t % FL)) begin errors++; $display("FAIL swp_tx t=%0d got %b want %b", t, tx, exp_tx(seq[t / FL], t % FL)); end
      if (t == FL - 1) begin
        checks++; if (fifo_count !== 3'd2) begin errors++; $display("FAIL swp_count_before got %0d want 2", fifo_count); end
      end
      if (t == FL) begin
        checks++; if (fifo_count !== 3'd2) begin errors++; $display("FAIL swp_count_after got %0d want 2", fifo_count); end
      end
    end
    wr_en = 1'b0;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL swp_busy_end got %b want 0", busy); end
    $display("test_simul_write_pop done");
  endtask

  task automatic test_full_write_pop();
    data_in = 8'h50; wr_en = 1'b1;
    tick();                       // edge N
    for (int t = 0; t < 5 * FL; t++) begin
      if (t < 4)        begin data_in = 8'(8'h51 + t); wr_en = 1'b1; end
      else if (t == FL) begin data_in = 8'h99; wr_en = 1'b1; end  // dropped: full
      else              begin wr_en = 1'b0; end
      tick();
      checks++; if (tx !== exp_tx(8'(8'h50 + t / FL), t % FL)) begin errors++; $display("FAIL fwp_tx t=%0d got %b want %b", t, tx, exp_tx(8'(8'h50 + t / FL), t % FL)); end
      if (t == FL - 1) begin
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL fwp_full_before got %b want 1", full); end
      end
      if (t == FL) begin
        checks++; if (fifo_count !== 3'd3) begin errors++; $display("FAIL fwp_count_after got %0d want 3", fifo_count); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL fwp_full_after got %b want 0", full); end
      end
    end
    wr_en = 1'b0;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fwp_busy_end got %b want 0", busy); end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL fwp_count_end got %0d want 0", fifo_count); end
    $display("test_full_write_pop done");
  endtask

  task automatic test_reset_mid_frame();
    int bad;
    data_in = 8'hFF; wr_en = 1'b1;
    tick();                       // edge N
    for (int t = 0; t < 70; t++) begin
      if (t == 0)      begin data_in = 8'h12; wr_en = 1'b1; end
      else if (t == 1) begin data_in = 8'h34; wr_en = 1'b1; end
      else             begin wr_en = 1'b0; end
      tick();
    end
    // t=69 is inside data bit 3 of 0xFF.
    checks++; if (tx !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL rmf_pre tx/busy got %b/%b want 1/1", tx, busy); end
    checks++; if (fifo_count !== 3'd2) begin errors++; $display("FAIL rmf_pre_count got %0d want 2", fifo_count); end
    rst_n = 1'b0;
    tick();
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL rmf_tx got %b want 1", tx); end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL rmf_count got %0d want 0", fifo_count); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmf_busy got %b want 0", busy); end
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 2 * FL; i++) begin
      tick();
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL rmf_no_frames got %0d bad cycles want 0", bad); end
    $display("test_reset_mid_frame done");
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    data_in = 8'h07; wr_en = 1'b1;
    tick();                       // edge N
    data_in = 8'h03;
    for (int t = 0; t < 2 * FL; t++) begin
      tick();
      wr_en = 1'b0;
      if (t == 9 * DIV + 8) begin
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL parity_07 got %b want 1", tx); end
      end
      if (t == FL - 1) begin
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL parity_stop got %b want 1", tx); end
      end
      if (t == FL) begin
        checks++; if (tx !== 1'b0) begin errors++; $display("FAIL parity_next_start got %b want 0", tx); end
      end
      if (t == FL + 9 * DIV + 8) begin
        checks++; if (tx !== 1'b0) begin errors++; $display("FAIL parity_03 got %b want 0", tx); end
      end
    end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL parity_busy_end got %b want 0", busy); end
    $display("test_parity done");
  endtask
`endif

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; data_in = 8'h00;
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_simul_write_pop();
    test_full_write_pop();
    test_reset_mid_frame();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
